fetch_stage: RTL and testbench

- PC generation, instruction-memory fetch and IF/ID pipeline register for the 5-stage RV32 core.
- Directly upstream of the load-use hazard detection in ID:
  - consumes its `stall`;
  - consumes the branch/jump redirect from EX;
  - presents the IF/ID fields (`rs1`, `rs2`, store flag) that the hazard check compares against ID/EX.
- Supports variable-latency instruction memory with one outstanding request.

---
 rtl/fetch_stage_pkg.sv | 15 +
 rtl/if_id_reg.sv | 51 +++++
 rtl/fetch_stage.sv | 114 +++++++++++
 tb/tb_fetch_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the RV32 fetch stage: store opcode, bubble word
// and the fetch FSM state encoding.
package fetch_stage_pkg;

   localparam logic [6:0]  OPCODE_STORE = 7'b0100011;
   localparam logic [31:0] NOP_INST_VAL = 32'h0000_0033;

   typedef enum logic [1:0] {
      ST_ISSUE = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DROP  = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats hold beats load, otherwise a bubble.
// Exposes the rs1/rs2/store fields the ID hazard check compares against.
module if_id_reg
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] NOP_INST = NOP_INST_VAL
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        hold,
   input  logic        load,
   input  logic [31:0] load_pc,
   input  logic [31:0] load_inst,
   output logic        valid,
   output logic [31:0] pc,
   output logic [31:0] pc4,
   output logic [31:0] inst,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic        mem_write
);

   // pc/pc4 are left untouched on bubbles; only valid and inst mark the slot empty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         pc    <= 32'd0;
         pc4   <= 32'd0;
         inst  <= NOP_INST;
      end else if (flush) begin
         valid <= 1'b0;
         inst  <= NOP_INST;
      end else if (hold) begin
         valid <= valid;
      end else if (load) begin
         valid <= 1'b1;
         pc    <= load_pc;
         pc4   <= load_pc + 32'd4;
         inst  <= load_inst;
      end else begin
         valid <= 1'b0;
         inst  <= NOP_INST;
      end
   end

   assign rs1       = valid ? inst[19:15] : 5'd0;
   assign rs2       = valid ? inst[24:20] : 5'd0;
   assign mem_write = valid && (inst[6:0] == OPCODE_STORE);

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, single-outstanding-request fetch FSM with a one-entry
// skid buffer for responses that land during a stall, feeding the IF/ID register.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = NOP_INST_VAL
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_rvalid,
   output logic        if_id_valid,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc4,
   output logic [31:0] if_id_inst,
   output logic [4:0]  if_id_rs1,
   output logic [4:0]  if_id_rs2,
   output logic        if_id_mem_write
);

   fetch_state_e state, state_next;
   logic [31:0]  pc, pc_next, pc_plus4;
   logic [31:0]  skid_buf;
   logic         capture;
   logic         deliver;
   logic [31:0]  deliver_inst;

   assign pc_plus4     = pc + 32'd4;
   assign imem_req     = rst_n && (state == ST_ISSUE) && !redirect_valid;
   assign imem_addr    = pc;
   assign deliver_inst = (state == ST_HOLD) ? skid_buf : imem_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_ISSUE;
         pc       <= RESET_PC;
         skid_buf <= 32'd0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
         if (capture) skid_buf <= imem_rdata;
      end
   end

   // Responses arriving in ISSUE or HOLD are protocol violations and are ignored
   always_comb begin
      state_next = state;
      pc_next    = pc;
      capture    = 1'b0;
      deliver    = 1'b0;
      case (state)
         ST_ISSUE: begin
            if (redirect_valid) pc_next = redirect_pc;
            else                state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (redirect_valid) begin
               pc_next    = redirect_pc;
               state_next = imem_rvalid ? ST_ISSUE : ST_DROP;
            end else if (imem_rvalid) begin
               if (!stall) begin
                  deliver    = 1'b1;
                  pc_next    = pc_plus4;
                  state_next = ST_ISSUE;
               end else begin
                  capture    = 1'b1;
                  state_next = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (redirect_valid) begin
               pc_next    = redirect_pc;
               state_next = ST_ISSUE;
            end else if (!stall) begin
               deliver    = 1'b1;
               pc_next    = pc_plus4;
               state_next = ST_ISSUE;
            end
         end
         ST_DROP: begin
            if (redirect_valid) pc_next = redirect_pc;
            if (imem_rvalid)    state_next = ST_ISSUE;
         end
         default: state_next = ST_ISSUE;
      endcase
   end

   if_id_reg #(
      .NOP_INST (NOP_INST)
   ) u_if_id (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_valid),
      .hold      (stall),
      .load      (deliver),
      .load_pc   (pc),
      .load_inst (deliver_inst),
      .valid     (if_id_valid),
      .pc        (if_id_pc),
      .pc4       (if_id_pc4),
      .inst      (if_id_inst),
      .rs1       (if_id_rs1),
      .rs2       (if_id_rs2),
      .mem_write (if_id_mem_write)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: hand-driven memory responses, stalls,
// redirects, PC wrap and mid-fetch reset, checked with immediate assertions.
module tb_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_rvalid;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc4;
   logic [31:0] if_id_inst;
   logic [4:0]  if_id_rs1;
   logic [4:0]  if_id_rs2;
   logic        if_id_mem_write;

   int assertCount;
   int failCount;

   localparam logic [31:0] NOP = 32'h0000_0033;

   fetch_stage dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_rdata      (imem_rdata),
      .imem_rvalid     (imem_rvalid),
      .if_id_valid     (if_id_valid),
      .if_id_pc        (if_id_pc),
      .if_id_pc4       (if_id_pc4),
      .if_id_inst      (if_id_inst),
      .if_id_rs1       (if_id_rs1),
      .if_id_rs2       (if_id_rs2),
      .if_id_mem_write (if_id_mem_write)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Wait for the next rising edge, then drive this cycle's inputs
   task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] rpc,
                                input logic rv, input logic [31:0] rdata);
      @(posedge clk);
      #1;
      stall          = st;
      redirect_valid = rd;
      redirect_pc    = rpc;
      imem_rvalid    = rv;
      imem_rdata     = rdata;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_req"},   {31'd0, imem_req},        32'd0);
      checkOutput({tag, "_valid"}, {31'd0, if_id_valid},     32'd0);
      checkOutput({tag, "_inst"},  if_id_inst,               NOP);
      checkOutput({tag, "_pc"},    if_id_pc,                 32'd0);
      checkOutput({tag, "_pc4"},   if_id_pc4,                32'd0);
      checkOutput({tag, "_rs1"},   {27'd0, if_id_rs1},       32'd0);
      checkOutput({tag, "_rs2"},   {27'd0, if_id_rs2},       32'd0);
      checkOutput({tag, "_mw"},    {31'd0, if_id_mem_write}, 32'd0);
   endtask

   initial begin
      assertCount    = 0;
      failCount      = 0;
      rst_n          = 1'b0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      imem_rvalid    = 1'b0;
      imem_rdata     = 32'd0;

      repeat (2) @(posedge clk);
      #2;
      checkResetValues("reset");

      // Release reset; first request at RESET_PC right away
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      checkOutput("first_req",  {31'd0, imem_req}, 32'd1);
      checkOutput("first_addr", imem_addr,         32'h0);

      // 1-cycle memory returns addi x1,x0,5
      applyStimulus(0, 0, 32'd0, 1, 32'h0050_0093);
      checkOutput("wait_req", {31'd0, imem_req}, 32'd0);
      applyStimulus(0, 0, 32'd0, 0, 32'd0);
      checkOutput("addi_valid", {31'd0, if_id_valid},     32'd1);
      checkOutput("addi_pc",    if_id_pc,                 32'h0);
      checkOutput("addi_pc4",   if_id_pc4,                32'h4);
      checkOutput("addi_inst",  if_id_inst,               32'h0050_0093);
      checkOutput("addi_rs1",   {27'd0, if_id_rs1},       32'd0);
      checkOutput("addi_rs2",   {27'd0, if_id_rs2},       32'd5);
      checkOutput("addi_mw",    {31'd0, if_id_mem_write}, 32'd0);
      checkOutput("addr_4",     imem_addr,                32'h4);
      checkOutput("req_4",      {31'd0, imem_req},        32'd1);

      // sw arrives under a 3-cycle stall, with a stray response during HOLD
      applyStimulus(1, 0, 32'd0, 1, 32'h0020_A023);
      checkOutput("bubble_valid", {31'd0, if_id_valid}, 32'd0);
      applyStimulus(1, 0, 32'd0, 1, 32'hDEAD_BEEF);
      checkOutput("hold1_req", {31'd0, imem_req}, 32'd0);
      applyStimulus(1, 0, 32'd0, 0, 32'd0);
      checkOutput("hold2_valid", {31'd0, if_id_valid}, 32'd0);
      applyStimulus(0, 0, 32'd0, 0, 32'd0);
      checkOutput("hold3_req", {31'd0, imem_req}, 32'd0);
      applyStimulus(1, 0, 32'd0, 0, 32'd0);
      checkOutput("sw_valid", {31'd0, if_id_valid},     32'd1);
      checkOutput("sw_inst",  if_id_inst,               32'h0020_A023);
      checkOutput("sw_pc",    if_id_pc,                 32'h4);
      checkOutput("sw_pc4",   if_id_pc4,                32'h8);
      checkOutput("sw_rs1",   {27'd0, if_id_rs1},       32'd1);
      checkOutput("sw_rs2",   {27'd0, if_id_rs2},       32'd2);
      checkOutput("sw_mw",    {31'd0, if_id_mem_write}, 32'd1);
      checkOutput("addr_8",   imem_addr,                32'h8);

      // Stall in ISSUE holds IF/ID; then redirect to 0x100 while in WAIT
      applyStimulus(0, 1, 32'h100, 0, 32'd0);
      checkOutput("stall_hold_valid", {31'd0, if_id_valid}, 32'd1);
      checkOutput("stall_hold_inst",  if_id_inst,           32'h0020_A023);
      checkOutput("redir_wait_req",   {31'd0, imem_req},    32'd0);
      applyStimulus(0, 0, 32'd0, 0, 32'd0);
      checkOutput("flush_valid", {31'd0, if_id_valid},     32'd0);
      checkOutput("flush_inst",  if_id_inst,               NOP);
      checkOutput("flush_rs1",   {27'd0, if_id_rs1},       32'd0);
      checkOutput("flush_rs2",   {27'd0, if_id_rs2},       32'd0);
      checkOutput("flush_mw",    {31'd0, if_id_mem_write}, 32'd0);
      checkOutput("drop_req",    {31'd0, imem_req},        32'd0);
      applyStimulus(0, 0, 32'd0, 1, 32'h0000_0013);
      checkOutput("drop2_req", {31'd0, imem_req}, 32'd0);
      applyStimulus(0, 0, 32'd0, 0, 32'd0);
      checkOutput("refetch_req",   {31'd0, imem_req},    32'd1);
      checkOutput("refetch_addr",  imem_addr,            32'h100);
      checkOutput("discard_valid", {31'd0, if_id_valid}, 32'd0);

      // Fetch addi x2,x0,10 at 0x100, then redirect+stall while in HOLD
      applyStimulus(0, 0, 32'd0, 1, 32'h00A0_0113);
      applyStimulus(1, 0, 32'd0, 0, 32'd0);
      checkOutput("a100_valid", {31'd0, if_id_valid}, 32'd1);
      checkOutput("a100_pc",    if_id_pc,             32'h100);
      checkOutput("a100_rs2",   {27'd0, if_id_rs2},   32'd10);
      checkOutput("addr_104",   imem_addr,            32'h104);
      applyStimulus(1, 0, 32'd0, 1, 32'h00C0_0193);
      checkOutput("a100_hold_inst", if_id_inst, 32'h00A0_0113);
      applyStimulus(1, 1, 32'h40, 0, 32'd0);
      checkOutput("hold_valid", {31'd0, if_id_valid}, 32'd1);
      checkOutput("hold_req",   {31'd0, imem_req},    32'd0);
      applyStimulus(0, 0, 32'd0, 0, 32'd0);
      checkOutput("rs_flush_valid", {31'd0, if_id_valid}, 32'd0);
      checkOutput("rs_flush_inst",  if_id_inst,           NOP);
      checkOutput("rs_flush_rs2",   {27'd0, if_id_rs2},   32'd0);
      checkOutput("req_40",         {31'd0, imem_req},    32'd1);
      checkOutput("addr_40",        imem_addr,            32'h40);

      // Redirect to 0xFFFF_FFFC via WAIT/DROP, then a redirect in ISSUE
      applyStimulus(0, 1, 32'hFFFF_FFFC, 0, 32'd0);
      applyStimulus(0, 0, 32'd0, 0, 32'd0);
      applyStimulus(0, 0, 32'd0, 1, 32'd0);
      applyStimulus(0, 1, 32'hFFFF_FFFC, 0, 32'd0);
      checkOutput("issue_redir_req", {31'd0, imem_req}, 32'd0);
      applyStimulus(0, 0, 32'd0, 0, 32'd0);
      checkOutput("wrap_req",  {31'd0, imem_req}, 32'd1);
      checkOutput("wrap_addr", imem_addr,         32'hFFFF_FFFC);
      applyStimulus(0, 0, 32'd0, 1, 32'h0000_0013);
      applyStimulus(0, 1, 32'h200, 0, 32'd0);
      checkOutput("wrap_valid",     {31'd0, if_id_valid}, 32'd1);
      checkOutput("wrap_pc",        if_id_pc,             32'hFFFF_FFFC);
      checkOutput("wrap_pc4",       if_id_pc4,            32'h0);
      checkOutput("wrap_next_addr", imem_addr,            32'h0);
      applyStimulus(0, 0, 32'd0, 0, 32'd0);
      checkOutput("addr_200", imem_addr, 32'h200);

      // Reset in the middle of WAIT at 0x200
      applyStimulus(0, 0, 32'd0, 0, 32'd0);
      checkOutput("pre_rst_req", {31'd0, imem_req}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      checkResetValues("midrst");
      @(posedge clk);
      #1;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h1234_5678;
      rst_n       = 1'b1;
      #1;
      checkOutput("post_rst_req",  {31'd0, imem_req}, 32'd1);
      checkOutput("post_rst_addr", imem_addr,         32'h0);
      applyStimulus(0, 0, 32'd0, 0, 32'd0);
      checkOutput("stale_valid", {31'd0, if_id_valid}, 32'd0);
      checkOutput("stale_req",   {31'd0, imem_req},    32'd0);
      applyStimulus(0, 0, 32'd0, 1, 32'h0050_0093);
      applyStimulus(0, 0, 32'd0, 0, 32'd0);
      checkOutput("post_rst_valid", {31'd0, if_id_valid}, 32'd1);
      checkOutput("post_rst_pc",    if_id_pc,             32'h0);
      checkOutput("post_rst_inst",  if_id_inst,           32'h0050_0093);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
